// File: rtl/pf_lanectrl_pause_sync_mc.sv
// Per-lane pause conditioner: synchronise async pause requests, stretch each pause to a
// minimum width and enforce a guard gap. Latency SYNC_STAGES+1 CLK edges (+1/2 cycle with
// PF_LANECTRL_PAUSE_FALL_EDGE_EN defined). No backpressure; requests are level-sampled.
module pf_lanectrl_pause_sync_mc #(
  parameter int NUM_LANES        = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 3,
  parameter int GUARD_CYCLES     = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  input  logic [NUM_LANES-1:0] LANE_EN,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic [NUM_LANES-1:0] PAUSE_BUSY,
  output logic                 PAUSE_ANY
);

  if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_num_lanes
    $error("NUM_LANES must be in 1..16");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 1..4");
  end
  if (MIN_PAUSE_CYCLES < 1 || MIN_PAUSE_CYCLES > 15) begin : g_bad_min_pause
    $error("MIN_PAUSE_CYCLES must be in 1..15");
  end
  if (GUARD_CYCLES < 0 || GUARD_CYCLES > 15) begin : g_bad_guard
    $error("GUARD_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [3:0] MIN_LOAD   = 4'(MIN_PAUSE_CYCLES - 1);
  localparam logic [3:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 4'(GUARD_CYCLES - 1) : 4'd0;
  localparam bit         HAS_GUARD  = (GUARD_CYCLES > 0);

  // Rising-edge PAUSE decode of every lane, before optional retiming.
  logic [NUM_LANES-1:0] pause_st;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_nx;
    logic [3:0]             cnt_q, cnt_nx;
    logic                   pend_q, pend_nx;
    logic                   pause_l, busy_l;

    // Synchroniser chain; deliberately ignores LANE_EN so a re-enabled lane sees live requests.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= HS_IO_CLK_PAUSE[i];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and pending-request registers.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_nx;
        cnt_q   <= cnt_nx;
        pend_q  <= pend_nx;
      end
    end

    // Next-state: min-width stretch in PAUSE, gap plus request capture in GUARD.
    always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      pend_nx  = pend_q;
      if (!LANE_EN[i]) begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
        pend_nx  = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (s) begin
              state_nx = ST_PAUSE;
              cnt_nx   = MIN_LOAD;
            end
          end
          ST_PAUSE: begin
            if (cnt_q != 4'd0) begin
              cnt_nx = cnt_q - 4'd1;
            end else if (!s) begin
              if (HAS_GUARD) begin
                state_nx = ST_GUARD;
                cnt_nx   = GUARD_LOAD;
              end else begin
                state_nx = ST_IDLE;
              end
            end
          end
          ST_GUARD: begin
            if (cnt_q != 4'd0) begin
              cnt_nx = cnt_q - 4'd1;
              if (s) pend_nx = 1'b1;
            end else begin
              // A request seen anywhere in the gap re-launches immediately after it.
              state_nx = (pend_q || s) ? ST_PAUSE : ST_IDLE;
              cnt_nx   = (pend_q || s) ? MIN_LOAD : 4'd0;
              pend_nx  = 1'b0;
            end
          end
          default: begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
            pend_nx  = 1'b0;
          end
        endcase
      end
    end

    // Outputs decoded from the state register only, never from inputs.
    always_comb begin
      pause_l = (state_q == ST_PAUSE);
      busy_l  = (state_q != ST_IDLE);
    end

    assign pause_st[i]   = pause_l;
    assign PAUSE_BUSY[i] = busy_l;
  end

`ifdef PF_LANECTRL_PAUSE_FALL_EDGE_EN
  logic [NUM_LANES-1:0] pause_fe_q;

  // Half-cycle retime of the pause outputs onto the falling edge.
  always_ff @(negedge CLK) begin
    if (RESET) begin
      pause_fe_q <= '0;
    end else begin
      pause_fe_q <= pause_st;
    end
  end

  assign HS_IO_CLK_PAUSE_SYNC = pause_fe_q;
`else
  assign HS_IO_CLK_PAUSE_SYNC = pause_st;
`endif

  assign PAUSE_ANY = |HS_IO_CLK_PAUSE_SYNC;

endmodule

// File: doc/pf_lanectrl_pause_sync_mc.md
# pf_lanectrl_pause_sync_mc

Multi-lane successor to the single-lane lane-controller pause synchroniser. For each of NUM_LANES lanes it:
- synchronises an asynchronous HS_IO_CLK_PAUSE request into the CLK domain through a configurable-depth flop chain;
- stretches every pause to a guaranteed minimum width;
- enforces a guard gap between consecutive pauses, so a lane controller never sees runt pauses or back-to-back pulses.

It sits between the fabric pause-request logic and the LANECTRL HS_IO_CLK_PAUSE pins of an IOD interface.

## Interface
Parameters:
- NUM_LANES, 4, number of independent lanes (1..16)
- SYNC_STAGES, 2, synchroniser depth per lane (1..4)
- MIN_PAUSE_CYCLES, 3, minimum asserted width of a pause output, in CLK cycles (1..15)
- GUARD_CYCLES, 2, minimum deasserted gap after each pause (0..15)

Ports:
- CLK  input  1  pause-domain clock; all logic on its rising edge, except the optional stage in Configuration
- RESET  input  1  reset; synchronous, active-high
- HS_IO_CLK_PAUSE  input  NUM_LANES  asynchronous per-lane pause requests
- LANE_EN  input  NUM_LANES  per-lane enable; synchronous to CLK
- HS_IO_CLK_PAUSE_SYNC  output  NUM_LANES  conditioned pause to LANECTRL
- PAUSE_BUSY  output  NUM_LANES  lane is in PAUSE or GUARD
- PAUSE_ANY  output  1  OR of all HS_IO_CLK_PAUSE_SYNC bits

## Operation
- Each lane has, independently:
  - a SYNC_STAGES-deep synchroniser; its last stage is called `s`;
  - a 3-state FSM: IDLE, PAUSE, GUARD;
  - a 4-bit down-counter `cnt`;
  - a `pend` flag.
- IDLE:
  - s=1 and LANE_EN=1 → PAUSE, cnt ← MIN_PAUSE_CYCLES-1.
- PAUSE:
  - Output is 1.
  - cnt decrements while nonzero.
  - When cnt==0 and s==0, the lane leaves PAUSE:
    - GUARD_CYCLES>0 → GUARD, cnt ← GUARD_CYCLES-1;
    - GUARD_CYCLES=0 → IDLE.
- GUARD:
  - Output is 0.
  - s=1 sets pend.
  - cnt decrements.
  - When cnt==0:
    - pend=1 or s=1 → PAUSE, cnt ← MIN_PAUSE_CYCLES-1, pend ← 0;
    - otherwise → IDLE, pend ← 0.
- Outputs:
  - HS_IO_CLK_PAUSE_SYNC[i] = (state==PAUSE), taken straight from the state register (no combinational path from inputs).
  - PAUSE_BUSY[i] = (state!=IDLE).
- LANE_EN[i]=0:
  - the lane is forced to IDLE on the next edge; pend and cnt are cleared;
  - the output drops even mid-pause;
  - the synchroniser keeps running.
- RESET sampled high:
  - all synchroniser stages, states, counters and pend flags clear;
  - all outputs are 0 after that edge;
  - applies even mid-PAUSE or mid-GUARD.
- Parameters outside their stated ranges are an elaboration error.

## Timing
- Assertion latency:
  - Request first captured at edge E1 → `s` high after edge E(SYNC_STAGES) → output high after edge E(SYNC_STAGES+1).
  - With defaults this is 3 edges.
- Pause width:
  - If `s` is high for L consecutive cycles, the output is high for exactly max(MIN_PAUSE_CYCLES, L) cycles.
  - Deassertion trails the request's fall by SYNC_STAGES+1 edges when L ≥ MIN_PAUSE_CYCLES.
- Gap:
  - After any pause the output stays low for at least max(GUARD_CYCLES, 1) cycles.
  - A request held or arriving during GUARD re-asserts the output on the cycle after GUARD ends.
- Sub-cycle glitches:
  - A glitch that any synchroniser stage captures yields a full MIN_PAUSE_CYCLES pulse.
  - A glitch that is never captured yields nothing.
- Lanes:
  - Lanes are fully independent; simultaneous requests on all lanes produce simultaneous outputs.
  - PAUSE_ANY is combinational from the registered outputs, so its latency equals theirs.

## Configuration
- PF_LANECTRL_PAUSE_FALL_EDGE_EN defined:
  - Each HS_IO_CLK_PAUSE_SYNC bit passes through one extra falling-edge CLK flop, adding ½ cycle of latency (e.g. 3.5 cycles with defaults).
  - That flop clears on the first falling edge at which RESET is high.
  - PAUSE_ANY is taken from the retimed bits.
  - PAUSE_BUSY is unaffected.
- Not defined: outputs come directly from the rising-edge state register.

## Test plan
All scenarios use default parameters unless noted.
- **Latency/min width:** lane 0 request high for 1 cycle, aligned to an edge → SYNC[0] high at cycles 3–5 (3 cycles wide), low ≥2 cycles after; other lanes stay 0.
- **Long pause:** lane 1 request held 10 cycles → SYNC[1] high for exactly 10 cycles; PAUSE_BUSY[1] high for 12 cycles; PAUSE_ANY tracks SYNC[1].
- **Guard pending:** lane 2 request 1 cycle, then a second 1-cycle request landing in GUARD → SYNC[2] pattern: 3 high, 2 low, 3 high, then 0.
- **Lane disable:** mid-PAUSE on lane 3, LANE_EN[3]=0 → SYNC[3] and BUSY[3] are 0 the next cycle; re-enable with request high → re-asserts after 1 cycle.
- **Reset mid-operation:** all 4 lanes paused; RESET high for 1 cycle → all outputs 0 after that edge; no output for SYNC_STAGES+1 edges after release, even with requests held high.
- **Sweep and macro:** SYNC_STAGES=4, MIN=1, GUARD=0 → 1-cycle request gives a 1-cycle output after 5 edges; repeat with PF_LANECTRL_PAUSE_FALL_EDGE_EN defined and check the ½-cycle shift.
